// File: rtl/digital_tube_driver.sv
// Latches CPU halfword writes into a 32-bit display word and scans its eight hex digits
// onto two 4-digit seven-segment groups. Optional TUBE_ZERO_BLANK_EN blanks leading zeros.
module digital_tube_driver #(
   parameter int unsigned CLK_DIV = 100000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tubectrl,
   input  logic        tubewrite,
   input  logic        tubeaddr,
   input  logic [15:0] tubewdata,
   input  logic        tube_en,
   output logic        tube_ack,
   output logic [7:0]  an,
   output logic [7:0]  seg_lo,
   output logic [7:0]  seg_hi
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [31:0]      data_q;
   logic [DIV_W-1:0] div_q;
   logic [1:0]       idx_q;
   logic             wr;
   logic [4:0]       lo_base;
   logic [4:0]       hi_base;
   logic [3:0]       nib_lo;
   logic [3:0]       nib_hi;
   logic             blank_lo;
   logic             blank_hi;
   logic [7:0]       an_next;

   // Segment pattern for one hex nibble, bit 0 = a .. bit 6 = g, dp off
   function automatic logic [7:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 8'h3F;
         4'h1: hex_seg = 8'h06;
         4'h2: hex_seg = 8'h5B;
         4'h3: hex_seg = 8'h4F;
         4'h4: hex_seg = 8'h66;
         4'h5: hex_seg = 8'h6D;
         4'h6: hex_seg = 8'h7D;
         4'h7: hex_seg = 8'h07;
         4'h8: hex_seg = 8'h7F;
         4'h9: hex_seg = 8'h6F;
         4'hA: hex_seg = 8'h77;
         4'hB: hex_seg = 8'h7C;
         4'hC: hex_seg = 8'h39;
         4'hD: hex_seg = 8'h5E;
         4'hE: hex_seg = 8'h79;
         default: hex_seg = 8'h71;
      endcase
   endfunction

   assign wr = tubectrl & tubewrite;

   // Digit selection for the current scan position of both groups
   always_comb begin
      lo_base = {1'b0, idx_q, 2'b00};
      hi_base = {1'b1, idx_q, 2'b00};
      nib_lo  = data_q[lo_base +: 4];
      nib_hi  = data_q[hi_base +: 4];
`ifdef TUBE_ZERO_BLANK_EN
      blank_lo = (idx_q != 2'd0) && ((data_q >> lo_base) == 32'd0);
      blank_hi = ((data_q >> hi_base) == 32'd0);
`else
      blank_lo = 1'b0;
      blank_hi = 1'b0;
`endif
      an_next = 8'h00;
      an_next[{1'b0, idx_q}] = ~blank_lo;
      an_next[{1'b1, idx_q}] = ~blank_hi;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         data_q   <= 32'd0;
         div_q    <= '0;
         idx_q    <= 2'd0;
         tube_ack <= 1'b0;
         an       <= 8'h00;
         seg_lo   <= 8'h00;
         seg_hi   <= 8'h00;
      end else begin
         tube_ack <= wr;
         if (wr) begin
            if (tubeaddr) data_q[31:16] <= tubewdata;
            else          data_q[15:0]  <= tubewdata;
         end
         // Disabled display holds the scan at position 0 so it restarts cleanly
         if (!tube_en) begin
            div_q  <= '0;
            idx_q  <= 2'd0;
            an     <= 8'h00;
            seg_lo <= 8'h00;
            seg_hi <= 8'h00;
         end else begin
            if (div_q == DIV_LAST) begin
               div_q <= '0;
               idx_q <= idx_q + 2'd1;
            end else begin
               div_q <= div_q + DIV_W'(1);
            end
            an     <= an_next;
            seg_lo <= blank_lo ? 8'h00 : hex_seg(nib_lo);
            seg_hi <= blank_hi ? 8'h00 : hex_seg(nib_hi);
         end
      end
   end

endmodule

// File: tb/tb_digital_tube_driver.sv
// Bench for digital_tube_driver: directed tables plus randomized traffic against a
// frame-arithmetic reference model, on a CLK_DIV=4 and a CLK_DIV=1 instance.
module tb_digital_tube_driver;

   logic        clk = 1'b0;
   logic        rst, tubectrl, tubewrite, tubeaddr, tube_en;
   logic [15:0] tubewdata;
   logic        ack4, ack1;
   logic [7:0]  an4, lo4, hi4, an1, lo1, hi1;

   int checks = 0;
   int errors = 0;

   logic [31:0] mdata;
   int          cnt;
   logic [7:0]  seg_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

   always #5 clk = ~clk;

   digital_tube_driver #(.CLK_DIV(4)) u_dut4 (
      .clk(clk), .rst(rst), .tubectrl(tubectrl), .tubewrite(tubewrite), .tubeaddr(tubeaddr),
      .tubewdata(tubewdata), .tube_en(tube_en), .tube_ack(ack4), .an(an4), .seg_lo(lo4), .seg_hi(hi4));

   digital_tube_driver #(.CLK_DIV(1)) u_dut1 (
      .clk(clk), .rst(rst), .tubectrl(tubectrl), .tubewrite(tubewrite), .tubeaddr(tubeaddr),
      .tubewdata(tubewdata), .tube_en(tube_en), .tube_ack(ack1), .an(an1), .seg_lo(lo1), .seg_hi(hi1));

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Expected display for digit position idx of each group, given the displayed word
   function automatic void model_out(input logic [31:0] d, input int idx,
                                     output logic [7:0] a, output logic [7:0] lo,
                                     output logic [7:0] hi);
      logic [31:0] rest_lo, rest_hi;
      rest_lo = d >> (4 * idx);
      rest_hi = d >> (4 * idx + 16);
      a  = 8'h00;
      a[idx] = 1'b1;
      a[idx + 4] = 1'b1;
      lo = seg_tab[rest_lo[3:0]];
      hi = seg_tab[rest_hi[3:0]];
`ifdef TUBE_ZERO_BLANK_EN
      if (idx > 0 && rest_lo == 32'd0) begin a[idx] = 1'b0; lo = 8'h00; end
      if (rest_hi == 32'd0) begin a[idx + 4] = 1'b0; hi = 8'h00; end
`endif
   endfunction

   // One clock: drive at negedge, predict, sample 1ns after posedge, return at next negedge
   task automatic step(input logic r, input logic c, input logic w, input logic a,
                       input logic [15:0] d, input logic e);
      logic [7:0] ea4, el4, eh4, ea1, el1, eh1;
      logic       eack;
      rst = r; tubectrl = c; tubewrite = w; tubeaddr = a; tubewdata = d; tube_en = e;
      {ea4, el4, eh4, ea1, el1, eh1} = '0;
      eack = 1'b0;
      if (!r) begin
         mdata = 32'd0;
         cnt   = 0;
      end else begin
         eack = c & w;
         if (e) begin
            model_out(mdata, (cnt / 4) % 4, ea4, el4, eh4);
            model_out(mdata, cnt % 4, ea1, el1, eh1);
            cnt++;
         end else begin
            cnt = 0;
         end
         if (c & w) begin
            if (a) mdata[31:16] = d;
            else   mdata[15:0]  = d;
         end
      end
      @(posedge clk);
      #1;
      chk("ack_div4", {7'd0, ack4}, {7'd0, eack});
      chk("an_div4", an4, ea4);
      chk("seglo_div4", lo4, el4);
      chk("seghi_div4", hi4, eh4);
      chk("ack_div1", {7'd0, ack1}, {7'd0, eack});
      chk("an_div1", an1, ea1);
      chk("seglo_div1", lo1, el1);
      chk("seghi_div1", hi1, eh1);
      @(negedge clk);
   endtask

   typedef struct {
      logic       r;
      logic       e;
      logic [7:0] an;
      logic [7:0] lo;
   } idle_vec_t;

   typedef struct {
      logic [7:0] an;
      logic [7:0] lo;
      logic [7:0] hi;
   } pair_vec_t;

   idle_vec_t idle_tab [11];
   pair_vec_t pair_tab [4];
   pair_vec_t hex_tab  [4];
   bit        seen [4];

   initial begin
      rst = 1'b0; tubectrl = 1'b0; tubewrite = 1'b0; tubeaddr = 1'b0;
      tubewdata = 16'h0; tube_en = 1'b1;
      mdata = 32'd0; cnt = 0;

      idle_tab[0] = '{1'b0, 1'b1, 8'h00, 8'h00};
      idle_tab[1] = '{1'b0, 1'b1, 8'h00, 8'h00};
      for (int i = 2; i < 11; i++) begin
`ifdef TUBE_ZERO_BLANK_EN
         idle_tab[i] = '{1'b1, 1'b1, (i < 6) ? 8'h01 : 8'h00, (i < 6) ? 8'h3F : 8'h00};
`else
         idle_tab[i] = '{1'b1, 1'b1, (i < 6) ? 8'h11 : ((i < 10) ? 8'h22 : 8'h44), 8'h3F};
`endif
      end
      pair_tab[0] = '{8'h11, 8'h7F, 8'h66};
      pair_tab[1] = '{8'h22, 8'h07, 8'h4F};
      pair_tab[2] = '{8'h44, 8'h7D, 8'h5B};
      pair_tab[3] = '{8'h88, 8'h6D, 8'h06};
      // 0xEF00ABCD: digits 0..7 = D,C,B,A,0,0,F,E
      hex_tab[0] = '{8'h11, 8'h5E, 8'h3F};
      hex_tab[1] = '{8'h22, 8'h39, 8'h3F};
      hex_tab[2] = '{8'h44, 8'h7C, 8'h71};
      hex_tab[3] = '{8'h88, 8'h77, 8'h79};

      @(negedge clk);

      // Reset and idle scan
      for (int i = 0; i < 11; i++) begin
         step(idle_tab[i].r, 1'b0, 1'b0, 1'b0, 16'h0, idle_tab[i].e);
         chk("idle_an", an4, idle_tab[i].an);
         chk("idle_seglo", lo4, idle_tab[i].lo);
      end

      // Halfword writes, then one frame of digit pairs
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'h5678, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'h1234, 1'b1);
      step(1'b1, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b1);
      for (int j = 0; j < 4; j++) seen[j] = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
         for (int j = 0; j < 4; j++) begin
            if (an4 == pair_tab[j].an) begin
               seen[j] = 1'b1;
               chk("pair_lo", lo4, pair_tab[j].lo);
               chk("pair_hi", hi4, pair_tab[j].hi);
            end
         end
      end
      for (int j = 0; j < 4; j++) chk("pair_seen", {7'd0, seen[j]}, 8'h01);

      // Hex letters with writes while disabled, then restart at position 0
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'hABCD, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 16'hEF00, 1'b0);
      chk("disabled_an", an4, 8'h00);
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
         if (i == 0) chk("restart_an", an4, 8'h11);
         chk("hex_an", an4, hex_tab[i / 4].an);
         chk("hex_lo", lo4, hex_tab[i / 4].lo);
         chk("hex_hi", hi4, hex_tab[i / 4].hi);
      end

      // Drop enable mid-frame, raise it again
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      chk("drop_en_an", an4, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("raise_en_an", an4, 8'h11);

      // Reset during a write discards it
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h9999, 1'b1);
      chk("rst_write_ack", {7'd0, ack4}, 8'h00);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
      chk("rst_write_seglo", lo4, 8'h3F);

      // Single nonzero digit pair: 0x000000A0
      step(1'b1, 1'b1, 1'b1, 1'b0, 16'h00A0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1);
`ifdef TUBE_ZERO_BLANK_EN
         chk("blank_an", an4, (i < 4) ? 8'h01 : 8'h02);
         chk("blank_lo", lo4, (i < 4) ? 8'h3F : 8'h77);
         chk("blank_hi", hi4, 8'h00);
`else
         chk("noblank_an", an4, (i < 4) ? 8'h11 : 8'h22);
         chk("noblank_lo", lo4, (i < 4) ? 8'h3F : 8'h77);
         chk("noblank_hi", hi4, 8'h3F);
`endif
      end

      // Randomized traffic against the model
      for (int i = 0; i < 600; i++) begin
         logic [15:0] d;
         d = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
         if ($urandom_range(0, 2) == 0) d = d & 16'h00F0;
         step(($urandom_range(0, 60) != 0), 1'($urandom), 1'($urandom), 1'($urandom), d,
              ($urandom_range(0, 15) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
